mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-ported val/wait memory between an instruction-fetch requester (port 0) and a data requester (port 1). It is the piece that allows a multicycle or pipelined TinyRV1 processor to run against a single memory, sitting between the processor's imem/dmem interfaces and the memory. The arbiter adds no latency: it uses a combinational grant path, a registered lock that holds the grant through memory wait states, and round-robin or fixed priority. Per-port stall counters support performance tracing.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose : shares one single-ported val/wait memory between an instruction
//           fetch requester (port 0) and a data requester (port 1).
// Latency : zero cycles; request -> mem_* and mem_wait/mem_rdata -> req* are combinational.
// Backpr. : the granted port sees mem_wait directly; a losing port with val=1 sees wait=1.
//           The grant is locked through memory wait states and released only on
//           completion or abort.
// Ports   : clk/rst (async, active-high); req0_* instruction port; req1_* data port;
//           mem_* memory side; stall0/1_count are saturating per-port stall-cycle counters.
module mem_arbiter #(
   parameter bit p_rr = 1'b1   // 1 = round-robin, 0 = port 1 always wins contention
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_val,
   output logic        req0_wait,
   input  logic        req0_type,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic [31:0] req0_rdata,

   input  logic        req1_val,
   output logic        req1_wait,
   input  logic        req1_type,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic [31:0] req1_rdata,

   output logic        mem_val,
   input  logic        mem_wait,
   output logic        mem_type,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,

   output logic [15:0] stall0_count,
   output logic [15:0] stall1_count
);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t state, state_nxt;
   logic   prio, prio_nxt;    // 0 = port 0 preferred on the next contention
   logic   gnt;               // some port owns the memory this cycle
   logic   gnt_sel;           // which port owns it (only meaningful with gnt)
   logic   mux_sel;

   // Read data is broadcast; each requester qualifies it with its own handshake.
   assign req0_rdata = mem_rdata;
   assign req1_rdata = mem_rdata;

   always_comb begin
      gnt       = 1'b0;
      gnt_sel   = 1'b0;
      state_nxt = IDLE;
      prio_nxt  = prio;

      // Reset is combinationally folded in so mem_val drops the instant rst rises,
      // even mid-lock, before the state register has been cleared by the edge.
      if (!rst) begin
         case (state)
            IDLE: begin
               if (req0_val && req1_val) begin
                  gnt     = 1'b1;
                  gnt_sel = p_rr ? prio : 1'b1;
               end else if (req0_val) begin
                  gnt     = 1'b1;
               end else if (req1_val) begin
                  gnt     = 1'b1;
                  gnt_sel = 1'b1;
               end
            end
            // A locked port keeps the memory regardless of the other port; if it
            // drops val mid-wait the transaction is abandoned (gnt=0 -> IDLE).
            LOCK0: gnt = req0_val;
            LOCK1: begin
               gnt     = req1_val;
               gnt_sel = 1'b1;
            end
            default: gnt = 1'b0;
         endcase
      end

      if (gnt) begin
         if (mem_wait) begin
            state_nxt = gnt_sel ? LOCK1 : LOCK0;
         end else if (p_rr) begin
            prio_nxt = ~gnt_sel;
         end
      end

      // With no grant the forwarded fields default to port 0.
      mux_sel   = gnt & gnt_sel;
      mem_val   = gnt;
      mem_type  = mux_sel ? req1_type  : req0_type;
      mem_addr  = mux_sel ? req1_addr  : req0_addr;
      mem_wdata = mux_sel ? req1_wdata : req0_wdata;

      // A port is released only when it owns the memory and the memory is ready.
      req0_wait = req0_val & ~(gnt & ~gnt_sel & ~mem_wait);
      req1_wait = req1_val & ~(gnt &  gnt_sel & ~mem_wait);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         prio  <= 1'b0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall0_count <= '0;
         stall1_count <= '0;
      end else begin
         if (req0_val && req0_wait && (stall0_count != 16'hFFFF))
            stall0_count <= stall0_count + 16'd1;
         if (req1_val && req1_wait && (stall1_count != 16'hFFFF))
            stall1_count <= stall1_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one round-robin instance and one fixed-priority
// instance share the same stimulus; both are checked against a memory-ownership
// model, plus a vector table and hand-written corner-case sequences.
module tb_mem_arbiter;

   typedef struct packed {
      logic        mem_val;
      logic        mem_type;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        w0;
      logic        w1;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [15:0] s0;
      logic [15:0] s1;
   } out_t;

   typedef struct {
      bit          v0, v1, mw;
      bit          ev;
      logic [31:0] ea;
      bit          ew0, ew1;
      int          es0, es1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        v0, v1, t0, t1, mw;
   logic [31:0] a0, a1, d0, d1, mrd;

   logic        o_mv [2];
   logic        o_mt [2];
   logic [31:0] o_ma [2];
   logic [31:0] o_md [2];
   logic        o_w0 [2];
   logic        o_w1 [2];
   logic [31:0] o_r0 [2];
   logic [31:0] o_r1 [2];
   logic [15:0] o_s0 [2];
   logic [15:0] o_s1 [2];
   out_t        o    [2];

   int   total  = 0;
   int   errors = 0;

   // model state, index 0 = round-robin instance, 1 = fixed priority
   int   owner_lock [2];   // port holding the memory across a wait, -1 if free
   int   pref       [2];   // preferred port on contention (round-robin only)
   int   cnt0       [2];
   int   cnt1       [2];
   int   own_m      [2];   // owner computed for the current cycle
   out_t exp_m      [2];

   vec_t tbl [11];

   always #5 clk = ~clk;

   mem_arbiter #(.p_rr(1'b1)) dut_rr (
      .clk(clk), .rst(rst),
      .req0_val(v0), .req0_wait(o_w0[0]), .req0_type(t0), .req0_addr(a0),
      .req0_wdata(d0), .req0_rdata(o_r0[0]),
      .req1_val(v1), .req1_wait(o_w1[0]), .req1_type(t1), .req1_addr(a1),
      .req1_wdata(d1), .req1_rdata(o_r1[0]),
      .mem_val(o_mv[0]), .mem_wait(mw), .mem_type(o_mt[0]), .mem_addr(o_ma[0]),
      .mem_wdata(o_md[0]), .mem_rdata(mrd),
      .stall0_count(o_s0[0]), .stall1_count(o_s1[0])
   );

   mem_arbiter #(.p_rr(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .req0_val(v0), .req0_wait(o_w0[1]), .req0_type(t0), .req0_addr(a0),
      .req0_wdata(d0), .req0_rdata(o_r0[1]),
      .req1_val(v1), .req1_wait(o_w1[1]), .req1_type(t1), .req1_addr(a1),
      .req1_wdata(d1), .req1_rdata(o_r1[1]),
      .mem_val(o_mv[1]), .mem_wait(mw), .mem_type(o_mt[1]), .mem_addr(o_ma[1]),
      .mem_wdata(o_md[1]), .mem_rdata(mrd),
      .stall0_count(o_s0[1]), .stall1_count(o_s1[1])
   );

   assign o[0] = {o_mv[0], o_mt[0], o_ma[0], o_md[0], o_w0[0], o_w1[0],
                  o_r0[0], o_r1[0], o_s0[0], o_s1[0]};
   assign o[1] = {o_mv[1], o_mt[1], o_ma[1], o_md[1], o_w0[1], o_w1[1],
                  o_r0[1], o_r1[1], o_s0[1], o_s1[1]};

   task automatic cmp(input string nm, input logic [163:0] act, input logic [163:0] req);
      total++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Who owns the memory this cycle, decided from the arbitration rules.
   function automatic out_t model_out(input int k, output int own);
      out_t e;
      own = -1;
      if (!rst) begin
         if (owner_lock[k] >= 0) begin
            if ((owner_lock[k] == 0) ? v0 : v1) own = owner_lock[k];
         end else if (v0 && v1) begin
            own = (k == 0) ? pref[k] : 1;
         end else if (v0) begin
            own = 0;
         end else if (v1) begin
            own = 1;
         end
      end
      e.mem_val   = (own >= 0);
      e.mem_type  = (own == 1) ? t1 : t0;
      e.mem_addr  = (own == 1) ? a1 : a0;
      e.mem_wdata = (own == 1) ? d1 : d0;
      e.w0        = v0 && !(own == 0 && !mw);
      e.w1        = v1 && !(own == 1 && !mw);
      e.rd0       = mrd;
      e.rd1       = mrd;
      e.s0        = 16'(cnt0[k]);
      e.s1        = 16'(cnt1[k]);
      return e;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         owner_lock[k] = -1;
         pref[k]       = 0;
         cnt0[k]       = 0;
         cnt1[k]       = 0;
         own_m[k]      = -1;
         exp_m[k]      = '0;
      end
   endtask

   task automatic check_models();
      for (int k = 0; k < 2; k++) begin
         exp_m[k] = model_out(k, own_m[k]);
         cmp((k == 0) ? "model_rr" : "model_fp", o[k], exp_m[k]);
      end
   endtask

   // Advance one clock and apply the end-of-cycle rules to the model.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            if (own_m[k] >= 0) begin
               owner_lock[k] = mw ? own_m[k] : -1;
               if (!mw && k == 0) pref[k] = (own_m[k] == 0) ? 1 : 0;
            end else begin
               owner_lock[k] = -1;
            end
            if (exp_m[k].w0 && cnt0[k] < 65535) cnt0[k]++;
            if (exp_m[k].w1 && cnt1[k] < 65535) cnt1[k]++;
         end
      end
      #1;
   endtask

   task automatic drive(input bit iv0, input bit iv1, input bit imw,
                        input logic [31:0] ia0, input logic [31:0] ia1);
      v0  = iv0;  v1 = iv1;  mw = imw;
      a0  = ia0;  a1 = ia1;
      t0  = 1'b0; t1 = 1'b1;
      d0  = ia0 ^ 32'hA5A5_0000;
      d1  = ia1 ^ 32'h5A5A_0000;
      mrd = $urandom;
   endtask

   task automatic step(input bit iv0, input bit iv1, input bit imw);
      drive(iv0, iv1, imw, 32'h200, 32'h300);
      #2;
      check_models();
   endtask

   // Leaves the bench at posedge+1 with rst released.
   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [66:0] act_v, req_v;
      bit          hold0, hold1;

      rst = 1'b1;
      model_reset();
      drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h300);
      #2;
      // reset state: mem idle, waits follow val, counters cleared
      cmp("rst_mem_val", 164'(o_mv[0]), 164'(0));
      cmp("rst_waits", 164'({o_w0[0], o_w1[0], o_w0[1], o_w1[1]}), 164'(4'b1111));
      cmp("rst_counts", 164'({o_s0[0], o_s1[0]}), 164'(0));
      check_models();
      do_reset();

      // 1) vector table: round-robin alternation, lock hold, uncontended port 0
      //            v0  v1  mw  ev  ea       ew0 ew1 es0 es1
      tbl[0]  = '{1, 1, 0, 1, 32'h200, 0, 1, 0, 0};
      tbl[1]  = '{1, 1, 0, 1, 32'h300, 1, 0, 0, 1};
      tbl[2]  = '{1, 1, 0, 1, 32'h200, 0, 1, 1, 1};
      tbl[3]  = '{1, 1, 0, 1, 32'h300, 1, 0, 1, 2};
      tbl[4]  = '{1, 0, 1, 1, 32'h200, 1, 0, 2, 2};
      tbl[5]  = '{1, 1, 1, 1, 32'h200, 1, 1, 3, 2};
      tbl[6]  = '{1, 1, 0, 1, 32'h200, 0, 1, 4, 3};
      tbl[7]  = '{0, 1, 0, 1, 32'h300, 0, 0, 4, 4};
      tbl[8]  = '{1, 0, 0, 1, 32'h200, 0, 0, 4, 4};
      tbl[9]  = '{1, 0, 0, 1, 32'h200, 0, 0, 4, 4};
      tbl[10] = '{1, 0, 0, 1, 32'h200, 0, 0, 4, 4};
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].v0, tbl[i].v1, tbl[i].mw);
         act_v = {o_mv[0], o_ma[0], o_w0[0], o_w1[0], o_s0[0], o_s1[0]};
         req_v = {tbl[i].ev, tbl[i].ea, tbl[i].ew0, tbl[i].ew1,
                  16'(tbl[i].es0), 16'(tbl[i].es1)};
         cmp($sformatf("tbl_row%0d", i), 164'(act_v), 164'(req_v));
         tick();
      end
      cmp("tbl_final_counts", 164'({o_s0[0], o_s1[0]}), 164'({16'd4, 16'd4}));

      // 2) fixed priority: port 1 wins every contention
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0);
         cmp("fp_addr", 164'({o_mv[1], o_ma[1], o_w0[1], o_w1[1]}),
             164'({1'b1, 32'h300, 1'b1, 1'b0}));
         tick();
      end
      cmp("fp_stall0", 164'(o_s0[1]), 164'(16'd3));

      // 3) async reset while locked on port 1
      do_reset();
      step(1'b0, 1'b1, 1'b1);
      tick();
      step(1'b1, 1'b1, 1'b1);
      cmp("lock1_addr", 164'({o_mv[0], o_ma[0]}), 164'({1'b1, 32'h300}));
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      cmp("arst_mem_val", 164'({o_mv[0], o_mv[1]}), 164'(0));
      cmp("arst_counts", 164'({o_s0[0], o_s1[0], o_s0[1], o_s1[1]}), 164'(0));
      check_models();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      check_models();
      tick();
      step(1'b1, 1'b1, 1'b0);
      cmp("post_rst_prio", 164'({o_mv[0], o_ma[0], o_w1[0]}), 164'({1'b1, 32'h200, 1'b1}));
      tick();

      // 4) randomized traffic against the ownership model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         hold0 = exp_m[0].w0 || exp_m[1].w0;
         hold1 = exp_m[0].w1 || exp_m[1].w1;
         if (!(hold0 && $urandom_range(19) != 0)) begin
            v0 = (hold0 ? 1'b0 : 1'($urandom_range(1)));
            t0 = 1'($urandom_range(1));
            a0 = $urandom & 32'hFFFF_FFFC;
            d0 = $urandom;
         end
         if (!(hold1 && $urandom_range(19) != 0)) begin
            v1 = (hold1 ? 1'b0 : 1'($urandom_range(1)));
            t1 = 1'($urandom_range(1));
            a1 = $urandom & 32'hFFFF_FFFC;
            d1 = $urandom;
         end
         mw  = ($urandom_range(9) < 3);
         mrd = $urandom;
         #2;
         check_models();
         tick();
      end

      // 5) stall counter saturation
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h300);
      repeat (70000) @(posedge clk);
      #1;
      cmp("sat_rr", 164'(o_s0[0]), 164'(16'hFFFF));
      cmp("sat_fp", 164'(o_s0[1]), 164'(16'hFFFF));
      @(posedge clk);
      #1;
      cmp("sat_nowrap", 164'(o_s0[0]), 164'(16'hFFFF));
      cmp("sat_port1", 164'(o_s1[0]), 164'(0));

      $display("test done: total=%0d bad=%0d", total, errors);
      $finish;
   end

endmodule
